// File: rtl/pipeline_fifo_arbiter_pkg.sv
// Shared state type and width helpers for the round-robin sink arbiter.
package pipeline_fifo_arbiter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    // Ceiling log2, never narrower than one bit so single-entry fields stay legal.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int span = 1; span < value; span = span * 2) begin
            result++;
        end
        return (result < 1) ? 1 : result;
    endfunction

    function automatic int idWidth(input int requesters);
        return clog2(requesters);
    endfunction

    function automatic int burstWidth(input int burstMax);
        return clog2(burstMax);
    endfunction

endpackage

// File: rtl/pipeline_fifo_arbiter_rr_next.sv
// Rotating-priority search: first requester after last_grant, wrapping, last_grant itself checked last.
module arbiter_rr_next
    import pipeline_fifo_arbiter_pkg::*;
#(
    parameter int REQUESTERS = 4,
    parameter int ID_WIDTH   = idWidth(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0] requests,
    input  logic [ID_WIDTH-1:0]   last_grant,
    output logic [ID_WIDTH-1:0]   next_index,
    output logic                  any_request
);

    int w_candidate;

    always_comb begin
        next_index  = '0;
        any_request = 1'b0;
        w_candidate = 0;
        for (int k = 1; k <= REQUESTERS; k++) begin
            w_candidate = int'(last_grant) + k;
            if (w_candidate >= REQUESTERS) begin
                w_candidate = w_candidate - REQUESTERS;
            end
            if (!any_request && requests[w_candidate[ID_WIDTH-1:0]]) begin
                any_request = 1'b1;
                next_index  = w_candidate[ID_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/pipeline_fifo_arbiter.sv
// Round-robin arbiter sharing one ready/valid sink among REQUESTERS sources with bounded bursts.
// Define PIPELINE_FIFO_ARBITER_LOCK_EN to hold each grant until the end-of-packet beat (input_last).
module pipeline_fifo_arbiter
    import pipeline_fifo_arbiter_pkg::*;
#(
    parameter int  WORD_WIDTH  = 8,
    parameter int  REQUESTERS  = 4,
    parameter int  BURST_MAX   = 4,
    localparam int ID_WIDTH    = idWidth(REQUESTERS),
    localparam int BURST_WIDTH = burstWidth(BURST_MAX)
) (
    input  logic                             clock,
    input  logic                             clear_n,
    input  logic [REQUESTERS-1:0]            input_valid,
    output logic [REQUESTERS-1:0]            input_ready,
    input  logic [REQUESTERS*WORD_WIDTH-1:0] input_data,
`ifdef PIPELINE_FIFO_ARBITER_LOCK_EN
    input  logic [REQUESTERS-1:0]            input_last,
`endif
    output logic                             output_valid,
    input  logic                             output_ready,
    output logic [WORD_WIDTH-1:0]            output_data,
    output logic [ID_WIDTH-1:0]              output_id
);

    state_t                 r_state;
    logic [ID_WIDTH-1:0]    r_grant;
    logic [ID_WIDTH-1:0]    r_lastGrant;
    logic [BURST_WIDTH-1:0] r_burstCount;

    state_t                 w_stateNext;
    logic [ID_WIDTH-1:0]    w_grantNext;
    logic [ID_WIDTH-1:0]    w_lastGrantNext;
    logic [BURST_WIDTH-1:0] w_burstNext;
    logic [ID_WIDTH-1:0]    w_nextIndex;
    logic                   w_anyRequest;
    logic                   w_active;
    logic [REQUESTERS-1:0]  w_sel;
    logic                   w_handshake;
    logic                   w_release;

`ifdef PIPELINE_FIFO_ARBITER_LOCK_EN
    logic                   r_midPacket;
    logic                   w_midPacketNext;
`else
    localparam logic [BURST_WIDTH-1:0] BURST_LAST = BURST_WIDTH'(BURST_MAX - 1);
`endif

    arbiter_rr_next #(
        .REQUESTERS (REQUESTERS),
        .ID_WIDTH   (ID_WIDTH)
    ) u_rrNext (
        .requests    (input_valid),
        .last_grant  (r_lastGrant),
        .next_index  (w_nextIndex),
        .any_request (w_anyRequest)
    );

    // Outputs are gated by clear_n too, so nothing handshakes while reset is held.
    assign w_active = (r_state == GRANTED) && clear_n;

    always_comb begin
        w_sel       = '0;
        output_data = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            w_sel[i]    = w_active && (r_grant == ID_WIDTH'(i));
            output_data = output_data
                        | (input_data[i*WORD_WIDTH +: WORD_WIDTH] & {WORD_WIDTH{w_sel[i]}});
        end
    end

    assign input_ready  = w_sel & {REQUESTERS{output_ready}};
    assign output_valid = |(w_sel & input_valid);
    assign output_id    = w_active ? r_grant : '0;
    assign w_handshake  = output_valid && output_ready;

    always_comb begin
        w_stateNext     = r_state;
        w_grantNext     = r_grant;
        w_lastGrantNext = r_lastGrant;
        w_burstNext     = r_burstCount;
        w_release       = 1'b0;
`ifdef PIPELINE_FIFO_ARBITER_LOCK_EN
        w_midPacketNext = r_midPacket;
`endif
        case (r_state)
            IDLE: begin
                if (w_anyRequest) begin
                    w_stateNext     = GRANTED;
                    w_grantNext     = w_nextIndex;
                    w_lastGrantNext = w_nextIndex;
                    w_burstNext     = '0;
                end
            end
            GRANTED: begin
                if (w_handshake) begin
                    w_burstNext = r_burstCount + 1'b1;
                end
`ifdef PIPELINE_FIFO_ARBITER_LOCK_EN
                if (w_handshake) begin
                    w_midPacketNext = !input_last[r_grant];
                end
                w_release = (w_handshake && input_last[r_grant])
                          || (!input_valid[r_grant] && !r_midPacket);
`else
                w_release = (w_handshake && (r_burstCount == BURST_LAST))
                          || !input_valid[r_grant];
`endif
                // The search wraps onto the current grant last, so a lone source re-wins without a bubble.
                if (w_release) begin
                    w_burstNext = '0;
                    if (w_anyRequest) begin
                        w_grantNext     = w_nextIndex;
                        w_lastGrantNext = w_nextIndex;
                    end else begin
                        w_stateNext = IDLE;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_lastGrant  <= ID_WIDTH'(REQUESTERS - 1);
            r_burstCount <= '0;
        end else begin
            r_state      <= w_stateNext;
            r_grant      <= w_grantNext;
            r_lastGrant  <= w_lastGrantNext;
            r_burstCount <= w_burstNext;
        end
    end

`ifdef PIPELINE_FIFO_ARBITER_LOCK_EN
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_midPacket <= 1'b0;
        end else begin
            r_midPacket <= w_midPacketNext;
        end
    end
`endif

endmodule
